ntt_coeff_loader: RTL and testbench



---
 rtl/ntt_pkg.sv | 36 +++
 rtl/ntt_coeff_loader.sv | 115 +++++++++++
 tb/tb_ntt_coeff_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and arithmetic helpers for the 16-point NTT datapath (q = 97).
package ntt_pkg;

  localparam int NTT_Q     = 97;
  localparam int NTT_N     = 16;
  localparam int NTT_LOG2N = 4;
  localparam int COEFF_W   = 7;
  // Widest raw coefficient the reduction helper handles; 2^RAW_W <= 3*NTT_Q.
  localparam int RAW_W     = 8;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } ldr_state_t;

  // Reverse the bit order of a 4-bit slot index.
  function automatic logic [NTT_LOG2N-1:0] bitrev4(input logic [NTT_LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  // Reduce x mod q using at most two conditional subtractions (x < 3q assumed).
  function automatic logic [COEFF_W-1:0] mod_reduce(input logic [RAW_W-1:0] x,
                                                    input logic [RAW_W-1:0] q);
    logic [RAW_W:0] xe;
    logic [RAW_W:0] qe;
    logic [RAW_W:0] q2;
    xe = {1'b0, x};
    qe = {1'b0, q};
    q2 = qe << 1;
    if (xe < qe)      return COEFF_W'(xe);
    else if (xe < q2) return COEFF_W'(xe - qe);
    else              return COEFF_W'(xe - q2);
  endfunction

endpackage

// File: rtl/ntt_coeff_loader.sv
// Serial coefficient ingest for the NTT core: reduce mod Q, store in
// bit-reversed slot order, present one parallel bus and hand off with start/done.
//
// state | meaning
// LOAD  | accepting beats of a frame (in_ready = 1)
// FIRE  | one cycle: ntt_start high, bus freshly loaded
// WAIT  | bus held until a rising edge of ntt_done
module ntt_coeff_loader
  import ntt_pkg::*;
#(
  parameter int Q      = NTT_Q,
  parameter int IN_W   = 8,
  parameter int BITREV = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_last,
  output logic [NTT_N*COEFF_W-1:0]   coeff_bus,
  output logic                       ntt_start,
  input  logic                       ntt_done,
  output logic                       busy,
  output logic                       frame_err,
  output logic [15:0]                frame_cnt
);

  localparam int BUS_W = NTT_N * COEFF_W;

  ldr_state_t                 state;
  logic [NTT_LOG2N-1:0]       cnt;
  logic                       done_q;
  logic [COEFF_W-1:0]         buf_mem  [NTT_N];
  logic [COEFF_W-1:0]         buf_next [NTT_N];
  logic [BUS_W-1:0]           bus_next;
  logic [NTT_LOG2N-1:0]       wr_slot;
  logic [COEFF_W-1:0]         wr_val;
  logic                       accept;
  logic                       cnt_full;

  assign in_ready = (state == ST_LOAD);
  assign accept   = in_valid && in_ready;
  assign cnt_full = (cnt == NTT_LOG2N'(NTT_N - 1));
  assign wr_slot  = (BITREV != 0) ? bitrev4(cnt) : cnt;
  assign wr_val   = mod_reduce(RAW_W'(in_data), RAW_W'(Q));

  // Buffer view including the beat being accepted this cycle, so the final
  // beat of a frame lands on the bus at the same edge that enters FIRE.
  always_comb begin
    buf_next = buf_mem;
    if (accept) buf_next[wr_slot] = wr_val;
    bus_next = '0;
    for (int k = 0; k < NTT_N; k++) begin
      bus_next[k*COEFF_W +: COEFF_W] = buf_next[k];
    end
  end

  // Coefficient buffer; contents are don't-care after reset or a bad frame.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[wr_slot] <= wr_val;
  end

  // Frame sequencing FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      coeff_bus <= '0;
      ntt_start <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      busy      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= ntt_done;
      ntt_start <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (cnt_full && in_last) begin
              state     <= ST_FIRE;
              cnt       <= '0;
              coeff_bus <= bus_next;
              ntt_start <= 1'b1;
              busy      <= 1'b1;
            end else if (cnt_full || in_last) begin
              frame_err <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_FIRE: begin
          frame_cnt <= frame_cnt + 1'b1;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // Edge-detect so a done level left over from the last frame is ignored.
          if (ntt_done && !done_q) begin
            state <= ST_LOAD;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_LOAD;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Scoreboard bench for ntt_coeff_loader: stimulus pushes expected bus/count per
// issued frame, a negedge monitor pops on every ntt_start and frame_err.
module tb_ntt_coeff_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'd0;
  logic         in_last = 1'b0;
  logic [111:0] coeff_bus;
  logic         ntt_start;
  logic         ntt_done = 1'b0;
  logic         busy;
  logic         frame_err;
  logic [15:0]  frame_cnt;

  ntt_coeff_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .coeff_bus (coeff_bus),
    .ntt_start (ntt_start),
    .ntt_done  (ntt_done),
    .busy      (busy),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [111:0] bus;
    logic [15:0]  cnt;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb [$];
  exp_t         mon_e;
  int           err_pending = 0;
  logic [15:0]  cnt_model = 16'd0;
  logic [111:0] last_bus = '0;
  logic [7:0]   fr [16];

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every start must match the oldest expected frame, every error pulse must be expected.
  always @(negedge clk) begin
    if (!rst) begin
      if (ntt_start) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: ntt_start=1 expected 0");
        end else begin
          mon_e = sb.pop_front();
          chk("start_bus", coeff_bus, mon_e.bus);
          chk("start_frame_cnt", 112'(frame_cnt), 112'(mon_e.cnt));
        end
      end
      if (frame_err) begin
        checks++;
        if (err_pending == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err: frame_err=1 expected 0");
        end else begin
          err_pending--;
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout: in_ready=0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v [16]);
    exp_t         e;
    logic [3:0]   n4;
    logic [3:0]   br;
    e.bus = '0;
    for (int n = 0; n < 16; n++) begin
      n4 = 4'(n);
      br = {n4[0], n4[1], n4[2], n4[3]};
      e.bus[br*7 +: 7] = 7'(v[n] % 8'd97);
    end
    e.cnt = cnt_model;
    sb.push_back(e);
    last_bus  = e.bus;
    cnt_model = cnt_model + 16'd1;
    for (int n = 0; n < 16; n++) send_beat(v[n], n == 15);
    chk("start_latency", 112'(ntt_start), 112'(1));
    chk("busy_in_fire", 112'(busy), 112'(1));
    chk("ready_in_fire", 112'(in_ready), 112'(0));
  endtask

  // Produce a clean done rising edge and check the loader reopens one cycle later.
  task automatic release_core();
    ntt_done = 1'b0;
    @(negedge clk);
    chk("ready_before_done", 112'(in_ready), 112'(0));
    chk("bus_hold_wait", coeff_bus, last_bus);
    ntt_done = 1'b1;
    @(negedge clk);
    chk("ready_after_done", 112'(in_ready), 112'(1));
    chk("busy_after_done", 112'(busy), 112'(0));
    chk("frame_cnt", 112'(frame_cnt), 112'(cnt_model));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 112'(in_ready), 112'(1));
    chk("rst_coeff_bus", coeff_bus, 112'(0));
    chk("rst_ntt_start", 112'(ntt_start), 112'(0));
    chk("rst_frame_err", 112'(frame_err), 112'(0));
    chk("rst_frame_cnt", 112'(frame_cnt), 112'(0));
    chk("rst_busy", 112'(busy), 112'(0));

    // Frame A: 1..16 in bit-reversed slots.
    for (int n = 0; n < 16; n++) fr[n] = 8'(n + 1);
    send_frame(fr);
    chk("slot1_is_9", 112'(coeff_bus[7 +: 7]), 112'(9));
    chk("slot8_is_2", 112'(coeff_bus[56 +: 7]), 112'(2));
    release_core();

    // Frame B: reduction boundaries; ntt_done stays high from frame A.
    for (int n = 0; n < 16; n++) fr[n] = 8'd0;
    fr[0] = 8'd96; fr[1] = 8'd97; fr[2] = 8'd200; fr[3] = 8'd194; fr[4] = 8'd255;
    send_frame(fr);
    chk("red_slot8_97", 112'(coeff_bus[56 +: 7]), 112'(0));
    chk("red_slot2_255", 112'(coeff_bus[14 +: 7]), 112'(61));
    // Stale done level must not exit WAIT; a pending beat must not be consumed.
    in_valid = 1'b1; in_data = 8'd33; in_last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stale_done_ready", 112'(in_ready), 112'(0));
      chk("stale_done_busy", 112'(busy), 112'(1));
      chk("stale_done_bus", coeff_bus, last_bus);
    end
    release_core();

    // Frame C begins with the beat held during WAIT.
    for (int n = 0; n < 16; n++) fr[n] = 8'(33 + 13 * n);
    send_frame(fr);
    release_core();

    // Early last on beat 5.
    err_pending++;
    for (int n = 0; n < 5; n++) send_beat(8'(50 + n), n == 4);
    chk("err1_pulse", 112'(frame_err), 112'(1));
    chk("err1_ready", 112'(in_ready), 112'(1));
    chk("err1_no_start", 112'(ntt_start), 112'(0));
    @(negedge clk);
    chk("err1_pulse_len", 112'(frame_err), 112'(0));

    // Sixteen beats without last.
    err_pending++;
    for (int n = 0; n < 16; n++) send_beat(8'(n), 1'b0);
    chk("err2_pulse", 112'(frame_err), 112'(1));
    chk("err2_no_start", 112'(ntt_start), 112'(0));

    // Clean frame after errors: frame count advances by exactly one.
    for (int n = 0; n < 16; n++) fr[n] = 8'(255 - 7 * n);
    send_frame(fr);
    release_core();

    // Reset after beat 10 aborts the frame silently.
    for (int n = 0; n < 10; n++) send_beat(8'(100 + n), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_model = 16'd0;
    chk("midrst_ready", 112'(in_ready), 112'(1));
    chk("midrst_bus", coeff_bus, 112'(0));
    chk("midrst_start", 112'(ntt_start), 112'(0));
    chk("midrst_err", 112'(frame_err), 112'(0));
    chk("midrst_frame_cnt", 112'(frame_cnt), 112'(0));
    for (int n = 0; n < 16; n++) fr[n] = 8'(16 - n);
    send_frame(fr);
    release_core();

    repeat (3) @(negedge clk);
    chk("sb_drained", 112'(sb.size()), 112'(0));
    chk("err_drained", 112'(err_pending), 112'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
